// File: rtl/inference_sequencer.sv
// -----------------------------------------------------------------------------
// inference_sequencer
// Frame-level controller for the streaming MNIST network. It waits for a VSYNC
// rising edge, clears the datapath, lets exactly NUM_PIXELS pixels stream in,
// then waits for each downstream stage's done pulse in order. Finally it hands
// the 4-bit class to a consumer under a valid/ready handshake. Stalled stages
// (timeout), short frames and unread results (overrun) are detected.
//
// Ports
//   i_clk           system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_start         level: 1 = keep classifying frames, 0 = stop after current
//   i_vsync         camera frame sync, synchronous to i_clk
//   i_pix_valid     one pixel accepted by the stream block this cycle
//   i_stage_done    one-cycle done pulses from the datapath stages
//   i_class_in      class from the output layer
//   i_result_ready  consumer accepts the result
//   i_err_clr       clears o_timeout_err and o_overrun
//   o_net_clear     one-cycle clear pulse to the datapath
//   o_stream_en     pixel stream block may accept pixels
//   o_stage_active  one-hot: stage currently awaited
//   o_result        latched class
//   o_result_valid  o_result holds an unread class
//   o_busy          sequencer is not idle
//   o_timeout_err   sticky: stream or stage stalled
//   o_overrun       sticky: a class was dropped because the result was unread
// -----------------------------------------------------------------------------
module inference_sequencer #(
    parameter int NUM_STAGES = 2,
    parameter int NUM_PIXELS = 784,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_vsync,
    input  logic                  i_pix_valid,
    input  logic [NUM_STAGES-1:0] i_stage_done,
    input  logic [3:0]            i_class_in,
    input  logic                  i_result_ready,
    input  logic                  i_err_clr,
    output logic                  o_net_clear,
    output logic                  o_stream_en,
    output logic [NUM_STAGES-1:0] o_stage_active,
    output logic [3:0]            o_result,
    output logic                  o_result_valid,
    output logic                  o_busy,
    output logic                  o_timeout_err,
    output logic                  o_overrun
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0] LAST_TMO = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_STREAM  = 3'd2,
        S_STAGE   = 3'd3,
        S_DELIVER = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                  r_vsync_q;
    logic [CNT_W-1:0]      r_pix_cnt;
    logic [CNT_W-1:0]      r_tmo_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_net_clear;
    logic                  r_stream_en;
    logic [NUM_STAGES-1:0] r_stage_active;
    logic [3:0]            r_result;
    logic                  r_result_valid;
    logic                  r_busy;
    logic                  r_timeout_err;
    logic                  r_overrun;

    logic [CNT_W-1:0]      w_pix_cnt_next;
    logic [CNT_W-1:0]      w_tmo_cnt_next;
    logic [IDX_W-1:0]      w_idx_next;
    logic                  w_net_clear_next;
    logic                  w_stream_en_next;
    logic [NUM_STAGES-1:0] w_stage_active_next;
    logic [3:0]            w_result_next;
    logic                  w_result_valid_next;
    logic                  w_busy_next;
    logic                  w_timeout_err_next;
    logic                  w_overrun_next;

    logic                  w_vs_rise;
    logic                  w_pix_last;
    logic                  w_stage_hit;
    logic                  w_stage_last;
    logic                  w_abort;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [NUM_STAGES-1:0] w_stage_onehot_inc;

    assign w_vs_rise    = i_vsync & ~r_vsync_q;
    assign w_pix_last   = i_pix_valid && (r_pix_cnt == LAST_PIX);
    // Only the bit of the awaited stage is looked at; early pulses are lost.
    assign w_stage_hit  = i_stage_done[r_idx];
    assign w_stage_last = (r_idx == LAST_IDX);
    assign w_idx_inc    = r_idx + 1'b1;

    // Abort only on cycles with no forward progress: any pixel or VSYNC edge
    // in STREAM, or the awaited done pulse in STAGE, restarts the idle count.
    assign w_abort = (r_tmo_cnt == LAST_TMO) &&
                     (((r_state == S_STREAM) && !i_pix_valid && !w_vs_rise) ||
                      ((r_state == S_STAGE) && !w_stage_hit));

    // One-hot code of the stage following the current one.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_onehot
            assign w_stage_onehot_inc[gi] = (w_idx_inc == IDX_W'(gi));
        end
    endgenerate

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = i_start ? S_ARM : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) w_state_next = S_ARM;
                end
                S_ARM: begin
                    // Nothing in flight yet, so a dropped start leaves at once.
                    if (!i_start)       w_state_next = S_IDLE;
                    else if (w_vs_rise) w_state_next = S_STREAM;
                end
                S_STREAM: begin
                    if (w_pix_last) w_state_next = S_STAGE;
                end
                S_STAGE: begin
                    if (w_stage_hit && w_stage_last) w_state_next = S_DELIVER;
                end
                S_DELIVER: begin
                    w_state_next = i_start ? S_ARM : S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Output / counter next-value logic; everything is registered below.
    always_comb begin
        w_net_clear_next    = 1'b0;
        w_stream_en_next    = r_stream_en;
        w_stage_active_next = r_stage_active;
        w_pix_cnt_next      = r_pix_cnt;
        w_tmo_cnt_next      = r_tmo_cnt;
        w_idx_next          = r_idx;
        w_result_next       = r_result;
        // A reload in DELIVER overrides this clear further down.
        w_result_valid_next = r_result_valid & ~i_result_ready;
        // Error sets further down override a simultaneous clear.
        w_timeout_err_next  = r_timeout_err & ~i_err_clr;
        w_overrun_next      = r_overrun & ~i_err_clr;
        w_busy_next         = (w_state_next != S_IDLE);

        if (w_abort) begin
            w_timeout_err_next  = 1'b1;
            w_net_clear_next    = 1'b1;
            w_stream_en_next    = 1'b0;
            w_stage_active_next = '0;
            w_pix_cnt_next      = '0;
            w_tmo_cnt_next      = '0;
            w_idx_next          = '0;
        end else begin
            case (r_state)
                S_ARM: begin
                    if (i_start && w_vs_rise) begin
                        w_net_clear_next = 1'b1;
                        w_stream_en_next = 1'b1;
                        w_pix_cnt_next   = '0;
                        w_tmo_cnt_next   = '0;
                    end
                end
                S_STREAM: begin
                    if (w_pix_last) begin
                        // The last pixel beats a coincident VSYNC edge.
                        w_stream_en_next    = 1'b0;
                        w_stage_active_next = FIRST_STAGE;
                        w_idx_next          = '0;
                        w_pix_cnt_next      = '0;
                        w_tmo_cnt_next      = '0;
                    end else if (w_vs_rise) begin
                        // Short frame: restart the count on the new frame.
                        w_net_clear_next = 1'b1;
                        w_pix_cnt_next   = '0;
                        w_tmo_cnt_next   = '0;
                    end else if (i_pix_valid) begin
                        w_pix_cnt_next = r_pix_cnt + 1'b1;
                        w_tmo_cnt_next = '0;
                    end else begin
                        w_tmo_cnt_next = r_tmo_cnt + 1'b1;
                    end
                end
                S_STAGE: begin
                    if (w_stage_hit) begin
                        w_tmo_cnt_next = '0;
                        if (w_stage_last) begin
                            w_stage_active_next = '0;
                            w_idx_next          = '0;
                        end else begin
                            w_idx_next          = w_idx_inc;
                            w_stage_active_next = w_stage_onehot_inc;
                        end
                    end else begin
                        w_tmo_cnt_next = r_tmo_cnt + 1'b1;
                    end
                end
                S_DELIVER: begin
                    if (!r_result_valid || i_result_ready) begin
                        w_result_next       = i_class_in;
                        w_result_valid_next = 1'b1;
                    end else begin
                        w_overrun_next = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vsync_q      <= 1'b0;
            r_pix_cnt      <= '0;
            r_tmo_cnt      <= '0;
            r_idx          <= '0;
            r_net_clear    <= 1'b0;
            r_stream_en    <= 1'b0;
            r_stage_active <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_vsync_q      <= i_vsync;
            r_pix_cnt      <= w_pix_cnt_next;
            r_tmo_cnt      <= w_tmo_cnt_next;
            r_idx          <= w_idx_next;
            r_net_clear    <= w_net_clear_next;
            r_stream_en    <= w_stream_en_next;
            r_stage_active <= w_stage_active_next;
            r_result       <= w_result_next;
            r_result_valid <= w_result_valid_next;
            r_busy         <= w_busy_next;
            r_timeout_err  <= w_timeout_err_next;
            r_overrun      <= w_overrun_next;
        end
    end

    assign o_net_clear    = r_net_clear;
    assign o_stream_en    = r_stream_en;
    assign o_stage_active = r_stage_active;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_busy         = r_busy;
    assign o_timeout_err  = r_timeout_err;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_inference_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inference_sequencer
// Self-checking bench for inference_sequencer with NUM_PIXELS=8, TIMEOUT=16,
// NUM_STAGES=2. Frames are driven with random pixel gaps, random stage delays
// and random classes; the expected result, valid and sticky flags come from a
// transaction-level model of the delivery rules.
// -----------------------------------------------------------------------------
module tb_inference_sequencer;

    localparam int NS = 2;
    localparam int NP = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          vsync;
    logic          pix_valid;
    logic [NS-1:0] stage_done;
    logic [3:0]    class_in;
    logic          result_ready;
    logic          err_clr;
    logic          net_clear;
    logic          stream_en;
    logic [NS-1:0] stage_active;
    logic [3:0]    result;
    logic          result_valid;
    logic          busy;
    logic          timeout_err;
    logic          overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    // Transaction-level model of the result interface and sticky flags.
    logic [3:0] m_result;
    logic       m_valid;
    logic       m_overrun;
    logic       m_timeout;

    always #5 clk = ~clk;

    inference_sequencer #(
        .NUM_STAGES (NS),
        .NUM_PIXELS (NP),
        .TIMEOUT    (TO),
        .CNT_W      (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_vsync        (vsync),
        .i_pix_valid    (pix_valid),
        .i_stage_done   (stage_done),
        .i_class_in     (class_in),
        .i_result_ready (result_ready),
        .i_err_clr      (err_clr),
        .o_net_clear    (net_clear),
        .o_stream_en    (stream_en),
        .o_stage_active (stage_active),
        .o_result       (result),
        .o_result_valid (result_valid),
        .o_busy         (busy),
        .o_timeout_err  (timeout_err),
        .o_overrun      (overrun)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_result  = '0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_timeout = 1'b0;
    endtask

    // A class is kept if the slot is free or being read; otherwise it is
    // dropped and overrun is flagged. An error set outranks a clear.
    task automatic model_deliver(input logic [3:0] cls, input logic rdy, input logic clr);
        if (clr) begin
            m_timeout = 1'b0;
            m_overrun = 1'b0;
        end
        if (!m_valid || rdy) begin
            m_result = cls;
            m_valid  = 1'b1;
        end else begin
            m_overrun = 1'b1;
        end
    endtask

    // VSYNC pulse from ARM, then pixels with random gaps until stream_en drops.
    task automatic drive_stream(output int pixels, output int clears, output bit ok);
        int   gap;
        logic pv;
        pixels = 0;
        clears = 0;
        gap    = 0;
        vsync  = 1'b1;
        tick();
        vsync = 1'b0;
        if (net_clear) clears++;
        for (int c = 0; c < 200; c++) begin
            if (!stream_en) break;
            pv  = (gap >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            gap = pv ? 0 : gap + 1;
            pix_valid = pv;
            tick();
            if (pv) pixels++;
            if (net_clear) clears++;
        end
        pix_valid = 1'b0;
        ok = !stream_en;
    endtask

    // Stage pulses in order with random delays (and stray pulses on the
    // inactive bit), then the single DELIVER cycle.
    task automatic drive_stages(input logic [3:0] cls, input logic rdy, input logic clr,
                                output int bad, output logic valid_in_deliver);
        logic [NS-1:0] exp_sa;
        int            d;
        bad      = 0;
        class_in = cls;
        for (int s = 0; s < NS; s++) begin
            exp_sa    = '0;
            exp_sa[s] = 1'b1;
            d = $urandom_range(0, 6);
            for (int k = 0; k < d; k++) begin
                if (stage_active !== exp_sa) bad++;
                stage_done = ($urandom_range(0, 1) == 1) ? ~exp_sa : '0;
                tick();
            end
            if (stage_active !== exp_sa) bad++;
            stage_done = exp_sa;
            tick();
            stage_done = '0;
        end
        if (stage_active !== '0) bad++;
        valid_in_deliver = result_valid;
        result_ready = rdy;
        err_clr      = clr;
        tick();
        result_ready = 1'b0;
        err_clr      = 1'b0;
        $display("[TB] frame class=%0d ready=%0d clr=%0d -> result=%0d valid=%0d overrun=%0d",
                 cls, rdy, clr, result, result_valid, overrun);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; vsync = 1'b0; pix_valid = 1'b0;
        stage_done = '0; class_in = '0; result_ready = 1'b0; err_clr = 1'b0;
        model_reset();
        #12;
        tests_run++;
        if ({net_clear, stream_en, stage_active, result, result_valid, busy, timeout_err, overrun} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {net_clear, stream_en, stage_active, result, result_valid, busy, timeout_err, overrun});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_busy: got %b required 0", busy);
        end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tests_run++;
        if ({net_clear, stream_en} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_ignores_vsync: got clear/en=%b required 00", {net_clear, stream_en});
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic_frame();
        int   px, cl, bad;
        bit   ok;
        logic vd, v_before;
        start = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL arm_busy: got %b required 1", busy);
        end
        drive_stream(px, cl, ok);
        tests_run++;
        if (!ok || px != NP || cl != 1) begin
            tests_failed++;
            $display("FAIL basic_stream: pixels=%0d clears=%0d done=%0d required %0d/1/1", px, cl, ok, NP);
        end
        v_before = m_valid;
        drive_stages(4'd7, 1'b0, 1'b0, bad, vd);
        model_deliver(4'd7, 1'b0, 1'b0);
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL basic_stage_active: %0d wrong cycles required 0", bad);
        end
        tests_run++;
        if (vd !== v_before) begin
            tests_failed++;
            $display("FAIL basic_latency: valid one cycle after done=%b required %b", vd, v_before);
        end
        tests_run++;
        if ({result, result_valid, busy} !== {m_result, m_valid, 1'b1}) begin
            tests_failed++;
            $display("FAIL basic_result: got result=%0d valid=%b busy=%b required %0d/%b/1",
                     result, result_valid, busy, m_result, m_valid);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        m_valid = 1'b0;
        tests_run++;
        if (result_valid !== m_valid) begin
            tests_failed++;
            $display("FAIL basic_consume: valid=%b required %b", result_valid, m_valid);
        end
    endtask

    task automatic test_short_frame();
        int         bad;
        logic       vd;
        logic [3:0] cls;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        pix_valid = 1'b1;
        repeat (5) tick();
        pix_valid = 1'b0;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tests_run++;
        if ({net_clear, stream_en} !== 2'b11) begin
            tests_failed++;
            $display("FAIL short_restart: clear/en=%b required 11", {net_clear, stream_en});
        end
        tick();
        pix_valid = 1'b1;
        repeat (NP - 1) tick();
        pix_valid = 1'b0;
        tests_run++;
        if ({net_clear, stream_en} !== 2'b01) begin
            tests_failed++;
            $display("FAIL short_needs_full_count: clear/en=%b required 01", {net_clear, stream_en});
        end
        // Last pixel coincides with a VSYNC edge: the pixel must win.
        pix_valid = 1'b1;
        vsync     = 1'b1;
        tick();
        pix_valid = 1'b0;
        vsync     = 1'b0;
        tests_run++;
        if ({net_clear, stream_en, stage_active} !== {2'b00, 2'b01}) begin
            tests_failed++;
            $display("FAIL short_tie: clear/en/active=%b required 0001", {net_clear, stream_en, stage_active});
        end
        cls = 4'($urandom_range(0, 15));
        drive_stages(cls, 1'b1, 1'b0, bad, vd);
        model_deliver(cls, 1'b1, 1'b0);
        tests_run++;
        if ({result, result_valid} !== {m_result, m_valid}) begin
            tests_failed++;
            $display("FAIL short_result: got %0d/%b required %0d/%b", result, result_valid, m_result, m_valid);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int         px, cl, bad;
        bit         ok;
        logic       vd;
        logic [3:0] cls;
        drive_stream(px, cl, ok);
        // Early pulse for stage 1 while stage 0 is awaited is lost.
        stage_done = 2'b10;
        tick();
        stage_done = '0;
        repeat (TO - 2) tick();
        tests_run++;
        if ({timeout_err, stage_active} !== 3'b001) begin
            tests_failed++;
            $display("FAIL timeout_early: err/active=%b required 001", {timeout_err, stage_active});
        end
        tick();
        m_timeout = 1'b1;
        tests_run++;
        if ({timeout_err, net_clear, stream_en, stage_active, busy} !== {m_timeout, 1'b1, 1'b0, 2'b00, 1'b1}) begin
            tests_failed++;
            $display("FAIL timeout_abort: err/clear/en/active/busy=%b required 110001",
                     {timeout_err, net_clear, stream_en, stage_active, busy});
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_timeout = 1'b0;
        tests_run++;
        if (timeout_err !== m_timeout) begin
            tests_failed++;
            $display("FAIL timeout_clear: err=%b required %b", timeout_err, m_timeout);
        end
        drive_stream(px, cl, ok);
        tests_run++;
        if (!ok || px != NP || cl != 1) begin
            tests_failed++;
            $display("FAIL timeout_rearm: pixels=%0d clears=%0d done=%0d required %0d/1/1", px, cl, ok, NP);
        end
        cls = 4'($urandom_range(0, 15));
        drive_stages(cls, 1'b0, 1'b0, bad, vd);
        model_deliver(cls, 1'b0, 1'b0);
        tests_run++;
        if ({result, result_valid, bad} !== {m_result, m_valid, 32'd0}) begin
            tests_failed++;
            $display("FAIL timeout_next_frame: got %0d/%b bad=%0d required %0d/%b bad=0",
                     result, result_valid, bad, m_result, m_valid);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic test_overrun();
        int         px, cl, bad;
        bit         ok;
        logic       vd;
        logic [3:0] cls_list [4];
        logic       rdy_list [4];
        logic       clr_list [4];
        cls_list = '{4'd3, 4'd5, 4'd9, 4'd4};
        rdy_list = '{1'b0, 1'b0, 1'b1, 1'b0};
        clr_list = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int f = 0; f < 4; f++) begin
            drive_stream(px, cl, ok);
            drive_stages(cls_list[f], rdy_list[f], clr_list[f], bad, vd);
            model_deliver(cls_list[f], rdy_list[f], clr_list[f]);
            tests_run++;
            if ({result, result_valid, overrun} !== {m_result, m_valid, m_overrun}) begin
                tests_failed++;
                $display("FAIL overrun_frame%0d: result/valid/overrun=%0d/%b/%b required %0d/%b/%b",
                         f, result, result_valid, overrun, m_result, m_valid, m_overrun);
            end
        end
        result_ready = 1'b1;
        err_clr      = 1'b1;
        tick();
        result_ready = 1'b0;
        err_clr      = 1'b0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        tests_run++;
        if ({result_valid, overrun} !== {m_valid, m_overrun}) begin
            tests_failed++;
            $display("FAIL overrun_clear: valid/overrun=%b required %b", {result_valid, overrun}, {m_valid, m_overrun});
        end
    endtask

    task automatic test_random_frames();
        int         px, cl, bad;
        bit         ok;
        logic       vd, v_before, rdy, clr;
        logic [3:0] cls;
        for (int f = 0; f < 10; f++) begin
            cls = 4'($urandom_range(0, 15));
            rdy = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 3) == 0);
            drive_stream(px, cl, ok);
            tests_run++;
            if (!ok || px != NP || cl != 1) begin
                tests_failed++;
                $display("FAIL rand%0d_stream: pixels=%0d clears=%0d done=%0d required %0d/1/1", f, px, cl, ok, NP);
            end
            v_before = m_valid;
            drive_stages(cls, rdy, clr, bad, vd);
            model_deliver(cls, rdy, clr);
            tests_run++;
            if (bad != 0 || vd !== v_before) begin
                tests_failed++;
                $display("FAIL rand%0d_stages: bad=%0d valid_in_deliver=%b required 0/%b", f, bad, vd, v_before);
            end
            tests_run++;
            if ({result, result_valid, overrun, timeout_err} !== {m_result, m_valid, m_overrun, m_timeout}) begin
                tests_failed++;
                $display("FAIL rand%0d_result: result/valid/ovr/tmo=%0d/%b/%b/%b required %0d/%b/%b/%b", f,
                         result, result_valid, overrun, timeout_err, m_result, m_valid, m_overrun, m_timeout);
            end
            if ($urandom_range(0, 1) == 1) begin
                result_ready = 1'b1;
                tick();
                result_ready = 1'b0;
                m_valid = 1'b0;
                tests_run++;
                if (result_valid !== m_valid) begin
                    tests_failed++;
                    $display("FAIL rand%0d_consume: valid=%b required %b", f, result_valid, m_valid);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int         px, cl, bad;
        bit         ok;
        logic       vd;
        logic [3:0] cls;
        // Leave an unread result so the reset has something visible to clear.
        drive_stream(px, cl, ok);
        drive_stages(4'd12, 1'b1, 1'b0, bad, vd);
        model_deliver(4'd12, 1'b1, 1'b0);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        pix_valid = 1'b1;
        repeat (3) tick();
        pix_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if ({net_clear, stream_en, stage_active, result, result_valid, busy, timeout_err, overrun} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got %b required all zero",
                     {net_clear, stream_en, stage_active, result, result_valid, busy, timeout_err, overrun});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({busy, net_clear} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_rearm: busy/clear=%b required 10", {busy, net_clear});
        end
        drive_stream(px, cl, ok);
        start = 1'b0;
        cls = 4'($urandom_range(0, 15));
        drive_stages(cls, 1'b0, 1'b0, bad, vd);
        model_deliver(cls, 1'b0, 1'b0);
        tests_run++;
        if ({busy, result, result_valid} !== {1'b0, m_result, m_valid}) begin
            tests_failed++;
            $display("FAIL stop_after_frame: busy/result/valid=%b/%0d/%b required 0/%0d/%b",
                     busy, result, result_valid, m_result, m_valid);
        end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        tests_run++;
        if ({busy, stream_en, net_clear} !== 3'b000) begin
            tests_failed++;
            $display("FAIL stopped_idle: busy/en/clear=%b required 000", {busy, stream_en, net_clear});
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_short_frame();
        test_timeout();
        test_overrun();
        test_random_frames();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
